// File: rtl/mpt_pkg.sv
// Shared types for the MPT walker memory path.
//   mptw_id_e        : identifies which walker owns a MEM-bus transaction
//   MPTW_NUM_MASTERS : number of walker masters merged by the arbiter
//   mptw_arb_state_e : arbiter FSM states
package mpt_pkg;

    typedef enum logic {
        MPTW_LOAD  = 1'b0,
        MPTW_STORE = 1'b1
    } mptw_id_e;

    localparam int MPTW_NUM_MASTERS = 2;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } mptw_arb_state_e;

endpackage

// File: rtl/mptw_mem_arbiter_id_fifo.sv
// In-order ID FIFO: remembers which walker owns each granted-but-unanswered
// MEM request so responses can be routed back in request order.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (pointers/count only)
//   push, data_in: enqueue one master ID (ignored when full)
//   pop, data_out: dequeue the head ID (ignored when empty); data_out is the head
//   full, empty  : occupancy flags
module mptw_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push,
    input  logic pop,
    input  logic data_in,
    output logic data_out,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign data_out = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage holds only data and needs no reset; validity is tracked by count.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/mptw_mem_arbiter.sv
// Merges the load-side and store-side MPT walker MEM-bus masters onto one
// MEM-bus port with round-robin arbitration and in-order response routing.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   s_mem_*               : per-walker slave side ([0]=load, [1]=store)
//   m_mem_*               : merged master side toward the dcache converter
//   proto_err_o           : sticky flag, response seen with nothing outstanding
module mptw_mem_arbiter
    import mpt_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 64
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [MPTW_NUM_MASTERS-1:0]                   s_mem_req,
    output logic [MPTW_NUM_MASTERS-1:0]                   s_mem_gnt,
    input  logic [MPTW_NUM_MASTERS-1:0][ADDR_WIDTH-1:0]   s_mem_addr,
    input  logic [MPTW_NUM_MASTERS-1:0][DATA_WIDTH-1:0]   s_mem_wdata,
    input  logic [MPTW_NUM_MASTERS-1:0]                   s_mem_we,
    input  logic [MPTW_NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] s_mem_be,
    output logic [MPTW_NUM_MASTERS-1:0]                   s_mem_valid,
    output logic [DATA_WIDTH-1:0]                         s_mem_rdata,
    output logic [MPTW_NUM_MASTERS-1:0]                   s_mem_error,
    output logic                                          m_mem_req,
    input  logic                                          m_mem_gnt,
    output logic [ADDR_WIDTH-1:0]                         m_mem_addr,
    output logic [DATA_WIDTH-1:0]                         m_mem_wdata,
    output logic                                          m_mem_we,
    output logic [DATA_WIDTH/8-1:0]                       m_mem_be,
    input  logic                                          m_mem_valid,
    input  logic [DATA_WIDTH-1:0]                         m_mem_rdata,
    input  logic                                          m_mem_error,
    output logic                                          proto_err_o
);

    mptw_arb_state_e state_q, state_d;
    mptw_id_e        locked_q, locked_d;
    mptw_id_e        last_gnt_q, last_gnt_d;
    logic            proto_err_q, proto_err_d;

    mptw_id_e        rr_pick;
    mptw_id_e        sel;
    logic            req_pending;
    logic            granted;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    mptw_id_e        head_id;

    mptw_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .data_in  (sel),
        .data_out (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign head_id     = mptw_id_e'(fifo_head);
    assign s_mem_rdata = m_mem_rdata;
    assign proto_err_o = proto_err_q;

    // Round robin: with both requesting, favour the master not granted last.
    always_comb begin
        rr_pick = MPTW_LOAD;
        if (s_mem_req == 2'b11) begin
            rr_pick = (last_gnt_q == MPTW_LOAD) ? MPTW_STORE : MPTW_LOAD;
        end else if (s_mem_req[MPTW_STORE]) begin
            rr_pick = MPTW_STORE;
        end
    end

    // Request path: a locked selection ignores the other master until it is
    // granted or withdraws. A full FIFO blocks the request even if a pop
    // happens this cycle, keeping grant independent of the response path.
    always_comb begin
        sel         = (state_q == ARB_LOCKED) ? locked_q : rr_pick;
        req_pending = (state_q == ARB_LOCKED) ? s_mem_req[locked_q] : |s_mem_req;
        m_mem_req   = !rst_i && !fifo_full && req_pending;
        granted     = m_mem_req && m_mem_gnt;
        fifo_push   = granted;

        s_mem_gnt      = '0;
        s_mem_gnt[sel] = granted;

        m_mem_addr  = '0;
        m_mem_wdata = '0;
        m_mem_we    = 1'b0;
        m_mem_be    = '0;
        if (m_mem_req) begin
            m_mem_addr  = s_mem_addr[sel];
            m_mem_wdata = s_mem_wdata[sel];
            m_mem_we    = s_mem_we[sel];
            m_mem_be    = s_mem_be[sel];
        end
    end

    // Response path: responses arrive in request order, so the FIFO head
    // names the owner. A response with nothing outstanding is dropped.
    always_comb begin
        fifo_pop             = !rst_i && m_mem_valid && !fifo_empty;
        s_mem_valid          = '0;
        s_mem_error          = '0;
        s_mem_valid[head_id] = fifo_pop;
        s_mem_error[head_id] = fifo_pop && m_mem_error;
        proto_err_d          = proto_err_q || (m_mem_valid && fifo_empty);
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        locked_d   = locked_q;
        last_gnt_d = granted ? sel : last_gnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (m_mem_req && !m_mem_gnt) begin
                    state_d  = ARB_LOCKED;
                    locked_d = sel;
                end
            end
            ARB_LOCKED: begin
                if (!s_mem_req[locked_q] || granted) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Last-granted starts at STORE so the first contested grant goes to LOAD.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            locked_q    <= MPTW_LOAD;
            last_gnt_q  <= MPTW_STORE;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            locked_q    <= locked_d;
            last_gnt_q  <= last_gnt_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule
